b2w_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that accepts a byte stream and returns it as 16-bit words, using an external dual-port block RAM of 512×8 (port A) / 256×16 (port B) as storage. Sits directly upstream and downstream of that RAM:
- It drives port A as a byte write port.
- It drives port B as a word read port.
- It presents the packed words to the consumer with a valid/ready handshake.

An explicit flush pads an odd trailing byte so that no data is stranded.

---
 rtl/b2w_pkg.sv | 13 +
 rtl/b2w_rd_stage.sv | 46 ++++
 rtl/b2w_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_b2w_fifo_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/b2w_pkg.sv
// Shared constants and state encoding for the byte-to-word FIFO controller.
package b2w_pkg;

    localparam int unsigned BYTE_AW     = 9;
    localparam int unsigned WORD_AW     = 8;
    localparam int unsigned DEPTH_BYTES = 512;

    typedef enum logic {
        RUN,
        PAD
    } state_e;

endpackage

// File: rtl/b2w_rd_stage.sv
// Word read side: issues port-B reads and holds OUT_VALID for the word on DOB.
module b2w_rd_stage
    import b2w_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_AW:0]   wr_word_ptr,
    input  logic               out_ready,
    output logic [WORD_AW:0]   rd_ptr,
    output logic               out_valid,
    output logic               issue,
    output logic [WORD_AW-1:0] rd_addr
);

    logic [WORD_AW:0] rd_ptr_q, rd_ptr_d;
    logic [WORD_AW:0] words_avail;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        words_avail = wr_word_ptr - rd_ptr_q;
        issue       = (words_avail != '0) & (~out_valid_q | out_ready);
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        if (issue) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rd_ptr    = rd_ptr_q;
    assign out_valid = out_valid_q;
    assign rd_addr   = rd_ptr_q[WORD_AW-1:0];

endmodule

// File: rtl/b2w_fifo_ctrl.sv
// Byte-in / 16-bit-word-out FIFO controller around an external 512x8 / 256x16 dual-port RAM.
module b2w_fifo_ctrl #(
    parameter int unsigned DEPTH_BYTES = 512
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        FLUSH,
    output logic        FLUSH_DONE,
    output logic [15:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [9:0]  LEVEL,
    output logic [8:0]  ADDRA,
    output logic [7:0]  DIA,
    output logic        ENA,
    output logic        WEA,
    output logic [7:0]  ADDRB,
    output logic        ENB,
    input  logic [15:0] DOB
);

    import b2w_pkg::*;

    state_e               state_q, state_d;
    logic [BYTE_AW:0]     wr_ptr_q, wr_ptr_d;
    logic                 flush_done_q, flush_done_d;
    logic [WORD_AW:0]     rd_ptr;
    logic                 out_valid;
    logic                 issue;
    logic [WORD_AW-1:0]   rd_addr;
    logic [BYTE_AW:0]     used_bytes;
    logic [BYTE_AW:0]     level;
    logic                 in_ready;
    logic                 accept;
    logic                 pad_wr;

    b2w_rd_stage u_rd_stage (
        .clk         (CLK),
        .rst_n       (RST_N),
        .wr_word_ptr (wr_ptr_q[BYTE_AW:1]),
        .out_ready   (OUT_READY),
        .rd_ptr      (rd_ptr),
        .out_valid   (out_valid),
        .issue       (issue),
        .rd_addr     (rd_addr)
    );

    // The word parked in the output stage stays in LEVEL until it is consumed.
    always_comb begin
        used_bytes = wr_ptr_q - {rd_ptr, 1'b0};
        level      = used_bytes + {{(BYTE_AW-1){1'b0}}, out_valid, 1'b0};
        in_ready   = RST_N & (state_q == RUN) & (level < (BYTE_AW+1)'(DEPTH_BYTES));
        accept     = IN_VALID & in_ready;
        pad_wr     = (state_q == PAD);
        wr_ptr_d   = wr_ptr_q + {{BYTE_AW{1'b0}}, accept | pad_wr};
    end

    // Parity is judged on the pointer after a same-edge byte write.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (FLUSH) begin
                    if (wr_ptr_d[0]) state_d      = PAD;
                    else             flush_done_d = 1'b1;
                end
            end
            PAD: begin
                state_d      = RUN;
                flush_done_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign IN_READY   = in_ready;
    assign FLUSH_DONE = flush_done_q;
    assign OUT_DATA   = DOB;
    assign OUT_VALID  = out_valid;
    assign LEVEL      = level;
    assign ENA        = accept | pad_wr;
    assign WEA        = accept | pad_wr;
    assign ADDRA      = wr_ptr_q[BYTE_AW-1:0];
    assign DIA        = pad_wr ? '0 : IN_DATA;
    assign ENB        = issue;
    assign ADDRB      = rd_addr;

endmodule

// File: tb/tb_b2w_fifo_ctrl.sv
// Directed bench for b2w_fifo_ctrl with a behavioural 512x8 / 256x16 RAM attached.
module tb_b2w_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        FLUSH = 1'b0;
    logic        FLUSH_DONE;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [9:0]  LEVEL;
    logic [8:0]  ADDRA;
    logic [7:0]  DIA;
    logic        ENA;
    logic        WEA;
    logic [7:0]  ADDRB;
    logic        ENB;
    logic [15:0] DOB = '0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] mem [512];

    always #5 CLK = ~CLK;

    b2w_fifo_ctrl #(.DEPTH_BYTES(512)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .FLUSH      (FLUSH),
        .FLUSH_DONE (FLUSH_DONE),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .LEVEL      (LEVEL),
        .ADDRA      (ADDRA),
        .DIA        (DIA),
        .ENA        (ENA),
        .WEA        (WEA),
        .ADDRB      (ADDRB),
        .ENB        (ENB),
        .DOB        (DOB)
    );

    always @(posedge CLK) begin
        if (ENA && WEA) mem[ADDRA] <= DIA;
        if (ENB) DOB <= {mem[{ADDRB, 1'b1}], mem[{ADDRB, 1'b0}]};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
        vectors++; if (IN_READY !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", IN_READY); end
        vectors++; if ({ENA, WEA, ENB} !== 3'b000) begin miscompares++; $display("FAIL reset_enables: got %b want 000", {ENA, WEA, ENB}); end
        vectors++; if (FLUSH_DONE !== 1'b0) begin miscompares++; $display("FAIL reset_flush_done: got %b want 0", FLUSH_DONE); end
        RST_N = 1'b1;
        step();
        vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", IN_READY); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL post_reset_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_pair();
        OUT_READY = 1'b0;
        IN_DATA = 8'h11; IN_VALID = 1'b1;
        step();
        IN_DATA = 8'h22;
        step();
        IN_VALID = 1'b0;
        #1;
        vectors++; if (ENB !== 1'b1) begin miscompares++; $display("FAIL pair_enb: got %b want 1", ENB); end
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL pair_valid_early: got %b want 0", OUT_VALID); end
        vectors++; if (LEVEL !== 10'd2) begin miscompares++; $display("FAIL pair_level_issued: got %0d want 2", LEVEL); end
        step();
        vectors++; if (OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL pair_valid: got %b want 1", OUT_VALID); end
        vectors++; if (OUT_DATA !== 16'h2211) begin miscompares++; $display("FAIL pair_data: got %h want 2211", OUT_DATA); end
        vectors++; if (LEVEL !== 10'd2) begin miscompares++; $display("FAIL pair_level_held: got %0d want 2", LEVEL); end
        vectors++; if (ENB !== 1'b0) begin miscompares++; $display("FAIL pair_enb_idle: got %b want 0", ENB); end
        step();
        vectors++; if (OUT_VALID !== 1'b1 || LEVEL !== 10'd2) begin miscompares++; $display("FAIL pair_hold: got valid=%b level=%0d want valid=1 level=2", OUT_VALID, LEVEL); end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL pair_consumed_valid: got %b want 0", OUT_VALID); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL pair_consumed_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_full();
        int unsigned ready_misses = 0;
        int unsigned k = 1;
        int unsigned bad = 0;
        logic [15:0] exp_w;
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 512; i++) begin
            IN_DATA = 8'(i);
            #1;
            if (IN_READY !== 1'b1) ready_misses++;
            step();
        end
        IN_VALID = 1'b0;
        #1;
        vectors++; if (ready_misses != 0) begin miscompares++; $display("FAIL full_ready_during_fill: got %0d stalls want 0", ready_misses); end
        vectors++; if (IN_READY !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", IN_READY); end
        vectors++; if (LEVEL !== 10'd512) begin miscompares++; $display("FAIL full_level: got %0d want 512", LEVEL); end
        vectors++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h0100) begin miscompares++; $display("FAIL full_head: got valid=%b data=%h want valid=1 data=0100", OUT_VALID, OUT_DATA); end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        vectors++; if (LEVEL !== 10'd510) begin miscompares++; $display("FAIL full_one_pop_level: got %0d want 510", LEVEL); end
        vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL full_one_pop_ready: got %b want 1", IN_READY); end
        vectors++; if (OUT_DATA !== 16'h0302) begin miscompares++; $display("FAIL full_next_word: got %h want 0302", OUT_DATA); end
        OUT_READY = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (LEVEL == 10'd0) break;
            if (OUT_VALID) begin
                exp_w = {8'(2 * k + 1), 8'(2 * k)};
                if (OUT_DATA !== exp_w) bad++;
                k++;
            end
            step();
        end
        OUT_READY = 1'b0;
        vectors++; if (bad != 0 || k != 256) begin miscompares++; $display("FAIL full_drain: got %0d bad words, %0d words seen, want 0 bad and 256", bad, k); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL full_drain_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_wrap();
        int unsigned sent = 0;
        int unsigned got = 0;
        logic [15:0] exp_w;
        for (int c = 0; c < 20000 && got < 600; c++) begin
            IN_VALID  = (sent < 1200) && ($urandom_range(0, 3) != 0);
            IN_DATA   = 8'(sent);
            OUT_READY = ($urandom_range(0, 2) != 0);
            #1;
            if (IN_VALID && IN_READY) sent++;
            if (OUT_VALID && OUT_READY) begin
                exp_w = {8'(2 * got + 1), 8'(2 * got)};
                vectors++;
                if (OUT_DATA !== exp_w) begin miscompares++; $display("FAIL wrap_word_%0d: got %h want %h", got, OUT_DATA, exp_w); end
                got++;
            end
            step();
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        vectors++; if (got != 600) begin miscompares++; $display("FAIL wrap_count: got %0d words want 600", got); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL wrap_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_flush_odd();
        OUT_READY = 1'b0;
        IN_DATA = 8'hA5; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        #1;
        vectors++; if (IN_READY !== 1'b0) begin miscompares++; $display("FAIL flush_odd_pad_ready: got %b want 0", IN_READY); end
        vectors++; if ({ENA, WEA} !== 2'b11 || DIA !== 8'h00) begin miscompares++; $display("FAIL flush_odd_pad_write: got ena/wea=%b dia=%h want 11 00", {ENA, WEA}, DIA); end
        vectors++; if (FLUSH_DONE !== 1'b0) begin miscompares++; $display("FAIL flush_odd_done_early: got %b want 0", FLUSH_DONE); end
        step();
        vectors++; if (FLUSH_DONE !== 1'b1) begin miscompares++; $display("FAIL flush_odd_done: got %b want 1", FLUSH_DONE); end
        vectors++; if (LEVEL !== 10'd2 || IN_READY !== 1'b1) begin miscompares++; $display("FAIL flush_odd_after: got level=%0d ready=%b want 2 1", LEVEL, IN_READY); end
        step();
        vectors++; if (FLUSH_DONE !== 1'b0) begin miscompares++; $display("FAIL flush_odd_done_pulse: got %b want 0", FLUSH_DONE); end
        vectors++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h00A5) begin miscompares++; $display("FAIL flush_odd_word: got valid=%b data=%h want 1 00a5", OUT_VALID, OUT_DATA); end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL flush_odd_drain: got %0d want 0", LEVEL); end
    endtask

    task automatic test_flush_even();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'h33;
        step();
        IN_DATA = 8'h44;
        step();
        IN_VALID = 1'b0;
        FLUSH = 1'b1;
        #1;
        vectors++; if (FLUSH_DONE !== 1'b0) begin miscompares++; $display("FAIL flush_even_done_early: got %b want 0", FLUSH_DONE); end
        step();
        FLUSH = 1'b0;
        #1;
        vectors++; if (FLUSH_DONE !== 1'b1) begin miscompares++; $display("FAIL flush_even_done: got %b want 1", FLUSH_DONE); end
        vectors++; if (ENA !== 1'b0) begin miscompares++; $display("FAIL flush_even_no_pad: got ena=%b want 0", ENA); end
        vectors++; if (LEVEL !== 10'd2) begin miscompares++; $display("FAIL flush_even_level: got %0d want 2", LEVEL); end
        step();
        vectors++; if (FLUSH_DONE !== 1'b0 || LEVEL !== 10'd2) begin miscompares++; $display("FAIL flush_even_after: got done=%b level=%0d want 0 2", FLUSH_DONE, LEVEL); end
        vectors++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h4433) begin miscompares++; $display("FAIL flush_even_word: got valid=%b data=%h want 1 4433", OUT_VALID, OUT_DATA); end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset_midstream();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 37; i++) begin
            IN_DATA = 8'(8'h40 + i);
            step();
        end
        IN_VALID = 1'b0;
        step();
        vectors++; if (LEVEL !== 10'd37 || OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got level=%0d valid=%b want 37 1", LEVEL, OUT_VALID); end
        #3;
        RST_N = 1'b0;
        #1;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", OUT_VALID); end
        vectors++; if (LEVEL !== 10'd0) begin miscompares++; $display("FAIL mid_rst_level: got %0d want 0", LEVEL); end
        vectors++; if (IN_READY !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0", IN_READY); end
        step();
        step();
        #3;
        RST_N = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 8'hC1;
        step();
        IN_DATA = 8'hC2;
        step();
        IN_VALID = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (OUT_VALID === 1'b1) break;
            step();
        end
        vectors++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'hC2C1) begin miscompares++; $display("FAIL mid_first_word: got valid=%b data=%h want 1 c2c1", OUT_VALID, OUT_DATA); end
        vectors++; if (LEVEL !== 10'd2) begin miscompares++; $display("FAIL mid_level: got %0d want 2", LEVEL); end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        vectors++; if (LEVEL !== 10'd0 || OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_drain: got level=%0d valid=%b want 0 0", LEVEL, OUT_VALID); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_full();
        test_wrap();
        test_flush_odd();
        test_flush_even();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
